// File: rtl/reset_seq_pkg.sv
// Shared types for the reset sequencer: FSM state encoding and its width.
package reset_seq_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        StHold    = 3'd0,
        StRelease = 3'd1,
        StRun     = 3'd2,
        StDone    = 3'd3
    } seq_state_t;

endpackage

// File: rtl/reset_sequencer_stagger.sv
// Combinational release decoder: which domains come out of reset on the current edge.
module stagger_release
    import reset_seq_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS    = 4,
    parameter int unsigned STAGGER_CYCLES = 2,
    parameter int unsigned STAG_W         = 3
) (
    input  logic                   i_start,
    input  logic                   i_en,
    input  logic [STAG_W-1:0]      i_cnt,
    output logic [NUM_DOMAINS-1:0] o_release,
    output logic                   o_last
);

    always_comb begin
        o_release = '0;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            // i_cnt is the stagger count after this edge, i.e. edges since domain 0 rose
            if (i_start) begin
                o_release[i] = (i == 0) || (STAGGER_CYCLES == 0);
            end else if (i_en) begin
                o_release[i] = (32'(i_cnt) >= STAGGER_CYCLES * 32'(i));
            end
        end
    end

    assign o_last = o_release[NUM_DOMAINS-1];

endmodule

// File: rtl/reset_sequencer.sv
// Reset/run controller: hold, staggered domain release, run-cycle counting and completion.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS    = 4,
    parameter int unsigned HOLD_CYCLES    = 3,
    parameter int unsigned STAGGER_CYCLES = 2,
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned RUN_LIMIT      = 100
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   sw_rst_req,
    input  logic                   halt_i,
    output logic [NUM_DOMAINS-1:0] domain_nrst_o,
    output logic                   run_o,
    output logic                   done_o,
    output logic                   timeout_o,
    output logic [CNT_W-1:0]       cycle_count_o,
    output logic [STATE_W-1:0]     state_o
);

    localparam int unsigned STAG_MAX = STAGGER_CYCLES * (NUM_DOMAINS - 1);
    localparam int unsigned STAG_W   = (STAG_MAX < 2) ? 1 : $clog2(STAG_MAX + 1);
    localparam int unsigned HOLD_W   = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam int unsigned LIMIT_M1 = (RUN_LIMIT == 0) ? 0 : RUN_LIMIT - 1;

    seq_state_t             r_state, w_state_d;
    logic [HOLD_W-1:0]      r_hold_cnt, w_hold_cnt_d;
    logic [STAG_W-1:0]      r_stag_cnt, w_stag_cnt_d;
    logic [NUM_DOMAINS-1:0] r_dom, w_dom_d;
    logic [CNT_W-1:0]       r_count, w_count_d;
    logic                   r_timeout, w_timeout_d;

    logic                   w_hold_exit;
    logic [STAG_W-1:0]      w_stag_inc;
    logic [NUM_DOMAINS-1:0] w_release;
    logic                   w_last;

    assign w_hold_exit = (r_state == StHold) && (r_hold_cnt == HOLD_W'(HOLD_CYCLES - 1));
    assign w_stag_inc  = r_stag_cnt + STAG_W'(1);

    stagger_release #(
        .NUM_DOMAINS    (NUM_DOMAINS),
        .STAGGER_CYCLES (STAGGER_CYCLES),
        .STAG_W         (STAG_W)
    ) u_stagger (
        .i_start   (w_hold_exit),
        .i_en      (r_state == StRelease),
        .i_cnt     (w_stag_inc),
        .o_release (w_release),
        .o_last    (w_last)
    );

    always_comb begin
        w_state_d    = r_state;
        w_hold_cnt_d = r_hold_cnt;
        w_stag_cnt_d = r_stag_cnt;
        w_dom_d      = r_dom;
        w_count_d    = r_count;
        w_timeout_d  = r_timeout;
        if (sw_rst_req) begin
            w_state_d    = StHold;
            w_hold_cnt_d = '0;
            w_stag_cnt_d = '0;
            w_dom_d      = '0;
            w_count_d    = '0;
            w_timeout_d  = 1'b0;
        end else begin
            unique case (r_state)
                StHold: begin
                    if (w_hold_exit) begin
                        w_dom_d      = r_dom | w_release;
                        w_stag_cnt_d = '0;
                        w_state_d    = w_last ? StRun : StRelease;
                    end else begin
                        w_hold_cnt_d = r_hold_cnt + HOLD_W'(1);
                    end
                end
                StRelease: begin
                    w_stag_cnt_d = w_stag_inc;
                    w_dom_d      = r_dom | w_release;
                    if (w_last) w_state_d = StRun;
                end
                StRun: begin
                    // halt has priority over the limit and freezes the pre-edge count
                    if (halt_i) begin
                        w_state_d = StDone;
                    end else if (RUN_LIMIT != 0 && r_count == CNT_W'(LIMIT_M1)) begin
                        w_state_d   = StDone;
                        w_timeout_d = 1'b1;
                        w_count_d   = CNT_W'(RUN_LIMIT);
                    end else if (r_count != '1) begin
                        w_count_d = r_count + CNT_W'(1);
                    end
                end
                StDone: ;
                default: w_state_d = StHold;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state    <= StHold;
            r_hold_cnt <= '0;
            r_stag_cnt <= '0;
            r_dom      <= '0;
            r_count    <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_hold_cnt <= w_hold_cnt_d;
            r_stag_cnt <= w_stag_cnt_d;
            r_dom      <= w_dom_d;
            r_count    <= w_count_d;
            r_timeout  <= w_timeout_d;
        end
    end

    assign domain_nrst_o = r_dom;
    assign run_o         = (r_state == StRun);
    assign done_o        = (r_state == StDone);
    assign timeout_o     = r_timeout;
    assign cycle_count_o = r_count;
    assign state_o       = r_state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench: defaults, a short run limit, and an 8-domain no-stagger configuration.
module tb_reset_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic        d_nrst = 1'b0, d_sw = 1'b0, d_halt = 1'b0;
    logic [3:0]  d_dom;
    logic        d_run, d_done, d_to;
    logic [15:0] d_cnt;
    logic [2:0]  d_st;

    logic        l_nrst = 1'b0, l_sw = 1'b0, l_halt = 1'b0;
    logic [3:0]  l_dom;
    logic        l_run, l_done, l_to;
    logic [15:0] l_cnt;
    logic [2:0]  l_st;

    logic        w_nrst = 1'b0, w_sw = 1'b0, w_halt = 1'b0;
    logic [7:0]  w_dom;
    logic        w_run, w_done, w_to;
    logic [15:0] w_cnt;
    logic [2:0]  w_st;

    reset_sequencer u_dut (
        .clk           (clk),
        .nrst          (d_nrst),
        .sw_rst_req    (d_sw),
        .halt_i        (d_halt),
        .domain_nrst_o (d_dom),
        .run_o         (d_run),
        .done_o        (d_done),
        .timeout_o     (d_to),
        .cycle_count_o (d_cnt),
        .state_o       (d_st)
    );

    reset_sequencer #(.RUN_LIMIT(10)) u_lim (
        .clk           (clk),
        .nrst          (l_nrst),
        .sw_rst_req    (l_sw),
        .halt_i        (l_halt),
        .domain_nrst_o (l_dom),
        .run_o         (l_run),
        .done_o        (l_done),
        .timeout_o     (l_to),
        .cycle_count_o (l_cnt),
        .state_o       (l_st)
    );

    reset_sequencer #(.NUM_DOMAINS(8), .STAGGER_CYCLES(0)) u_wide (
        .clk           (clk),
        .nrst          (w_nrst),
        .sw_rst_req    (w_sw),
        .halt_i        (w_halt),
        .domain_nrst_o (w_dom),
        .run_o         (w_run),
        .done_o        (w_done),
        .timeout_o     (w_to),
        .cycle_count_o (w_cnt),
        .state_o       (w_st)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_d(input string tag, input logic [3:0] dom, input logic [2:0] st,
                           input logic [15:0] cnt, input logic to);
        check({tag, ".dom"}, 32'(d_dom), 32'(dom));
        check({tag, ".state"}, 32'(d_st), 32'(st));
        check({tag, ".run"}, 32'(d_run), 32'(st == 3'd2));
        check({tag, ".done"}, 32'(d_done), 32'(st == 3'd3));
        check({tag, ".count"}, 32'(d_cnt), 32'(cnt));
        check({tag, ".timeout"}, 32'(d_to), 32'(to));
    endtask

    task automatic release_seq(input string tag);
        tick(2);
        check_d({tag, ".e2"}, 4'b0000, 3'd0, 16'd0, 1'b0);
        tick(1);
        check_d({tag, ".e3"}, 4'b0001, 3'd1, 16'd0, 1'b0);
        tick(2);
        check_d({tag, ".e5"}, 4'b0011, 3'd1, 16'd0, 1'b0);
        tick(2);
        check_d({tag, ".e7"}, 4'b0111, 3'd1, 16'd0, 1'b0);
        tick(2);
        check_d({tag, ".e9"}, 4'b1111, 3'd2, 16'd0, 1'b0);
    endtask

    initial begin
        tick(3);
        check_d("reset", 4'b0000, 3'd0, 16'd0, 1'b0);

        d_nrst = 1'b1;
        release_seq("rel");
        tick(25);
        check_d("run25", 4'b1111, 3'd2, 16'd25, 1'b0);

        d_sw = 1'b1;
        tick(1);
        d_sw = 1'b0;
        check_d("swrst", 4'b0000, 3'd0, 16'd0, 1'b0);
        release_seq("replay");

        tick(40);
        check_d("run40", 4'b1111, 3'd2, 16'd40, 1'b0);
        d_halt = 1'b1;
        tick(1);
        d_halt = 1'b0;
        check_d("halt", 4'b1111, 3'd3, 16'd40, 1'b0);
        tick(3);
        d_halt = 1'b1;
        tick(2);
        d_halt = 1'b0;
        check_d("halt_ignored", 4'b1111, 3'd3, 16'd40, 1'b0);

        d_sw = 1'b1;
        tick(1);
        d_sw = 1'b0;
        tick(9);
        check_d("rerun", 4'b1111, 3'd2, 16'd0, 1'b0);
        tick(99);
        check_d("run99", 4'b1111, 3'd2, 16'd99, 1'b0);
        tick(1);
        check_d("timeout", 4'b1111, 3'd3, 16'd100, 1'b1);
        tick(20);
        check_d("timeout_hold", 4'b1111, 3'd3, 16'd100, 1'b1);

        d_sw = 1'b1;
        tick(1);
        d_sw = 1'b0;
        tick(5);
        check_d("mid_release", 4'b0011, 3'd1, 16'd0, 1'b0);
        #2 d_nrst = 1'b0;
        #1;
        check_d("async_abort", 4'b0000, 3'd0, 16'd0, 1'b0);

        l_nrst = 1'b1;
        tick(9);
        check("lim.run", 32'(l_run), 32'd1);
        check("lim.dom", 32'(l_dom), 32'hF);
        tick(9);
        check("lim.count9", 32'(l_cnt), 32'd9);
        l_halt = 1'b1;
        tick(1);
        l_halt = 1'b0;
        check("lim.done", 32'(l_done), 32'd1);
        check("lim.timeout", 32'(l_to), 32'd0);
        check("lim.count", 32'(l_cnt), 32'd9);

        w_nrst = 1'b1;
        tick(2);
        check("wide.e2_dom", 32'(w_dom), 32'h00);
        tick(1);
        check("wide.e3_dom", 32'(w_dom), 32'hFF);
        check("wide.e3_state", 32'(w_st), 32'd2);
        check("wide.e3_run", 32'(w_run), 32'd1);
        check("wide.e3_count", 32'(w_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Parametrised, synthesizable reset and run controller that sits between the board/bench clock-reset source and the `system` top.
- Holds all reset domains for a programmable time after `nrst` rises.
- Releases N domain resets in staggered order.
- Counts run cycles after release and flags completion on a CPU halt or a cycle-limit timeout.
- Accepts a software reset request that replays the whole sequence without toggling `nrst`.

Parameters:
NUM_DOMAINS, 4, number of downstream reset domains (≥1)
HOLD_CYCLES, 3, clk edges with `nrst` high before domain 0 is released (≥1)
STAGGER_CYCLES, 2, clk edges between release of domain i and domain i+1 (0 = release all together)
CNT_W, 16, width of the run-cycle counter
RUN_LIMIT, 100, RUN cycles before timeout (0 = unlimited; must be < 2**CNT_W)

Ports:
clk  in  1  system clock
nrst  in  1  asynchronous active-low reset
sw_rst_req  in  1  software reset request; sampled on clk
halt_i  in  1  CPU halt indication; sampled on clk
domain_nrst_o  out  NUM_DOMAINS  per-domain active-low reset; bit 0 released first
run_o  out  1  high while in RUN
done_o  out  1  high in DONE
timeout_o  out  1  high in DONE when entry cause was RUN_LIMIT
cycle_count_o  out  CNT_W  RUN cycles elapsed
state_o  out  3  current FSM state encoding

Behaviour:
- Clock and reset: one clock (`clk`). Reset is asynchronous and active-low (`nrst`).
- While `nrst` is low, all flops are cleared immediately and asynchronously:
  - state=HOLD, domain_nrst_o=0, run_o=0, done_o=0, timeout_o=0, cycle_count_o=0.
  - Internal hold and stagger counters=0.
- FSM states: HOLD(0), RELEASE(1), RUN(2), DONE(3).
- HOLD:
  - The hold counter increments on each edge with `nrst` high.
  - On the HOLD_CYCLES-th edge, go to RELEASE and set domain_nrst_o[0]=1 on that same edge.
- RELEASE:
  - The stagger counter counts edges.
  - Domain i goes high STAGGER_CYCLES·i edges after domain 0.
  - The edge that raises the last domain also enters RUN.
  - With STAGGER_CYCLES=0 or NUM_DOMAINS=1, all domains go high on the HOLD exit edge and the state goes straight to RUN (RELEASE is skipped).
  - Released domains never re-assert except on sw_rst_req or `nrst`.
- RUN:
  - run_o=1.
  - cycle_count increments by 1 each edge and saturates at 2**CNT_W−1.
  - If halt_i=1 is sampled: DONE, done_o=1, timeout_o=0, count frozen at its pre-edge value.
  - Else, if RUN_LIMIT≠0 and the count reaches RUN_LIMIT on this edge: DONE, done_o=1, timeout_o=1, count=RUN_LIMIT.
  - If halt and limit occur on the same edge, halt wins (timeout_o=0).
- DONE:
  - Terminal state; outputs hold; domains stay released.
  - halt_i is ignored.
- sw_rst_req=1 sampled in any state:
  - On the next edge, domain_nrst_o=0 (all bits, synchronous), state=HOLD.
  - All counters, done_o and timeout_o are cleared.
  - It has priority over every other transition. Holding it high keeps the block in HOLD with the hold counter at 0.
- `nrst` low mid-sequence (any state) aborts immediately to the reset values. The sequence restarts fully after release.
- Domain outputs are driven directly from flops, so they are glitch-free.

Decomposition:
- Package `reset_seq_pkg`:
  - `seq_state_t` enum (3-bit: HOLD, RELEASE, RUN, DONE).
  - Localparam for the state width.
- One sub-module, `stagger_release`:
  - Takes the start pulse and the stagger counter.
  - Produces the NUM_DOMAINS release vector and a last-domain-released flag.
- The top holds the FSM and the run counter.

Test Plan:
- Defaults; `nrst` low 3 edges, then high → domain_nrst_o = 0001 at edge 3, 0011 at 5, 0111 at 7, 1111 at 9 with run_o=1 on edge 9; cycle_count_o=0.
- Defaults, no halt → after 100 RUN edges: done_o=1, timeout_o=1, cycle_count_o=100; holds for 20 further edges.
- halt_i pulsed when cycle_count_o=40 → done_o=1, timeout_o=0, count stays 40; later halt_i toggles are ignored.
- RUN_LIMIT=10 with halt_i high on the edge the count would reach 10 → done_o=1, timeout_o=0, count 9.
- sw_rst_req pulsed in RUN at count 25 → next edge domain_nrst_o=0000, count 0, state HOLD; the full release sequence replays with identical timing.
- `nrst` driven low mid-RELEASE (domains 0011) → all outputs 0 in the same delta without a clock edge. Then:
  - With STAGGER_CYCLES=0, NUM_DOMAINS=8 → all 8 bits rise together at edge 3.
